mux_4to1_rr: RTL
================

MUX_4TO1_RR -- requirements
Module: mux_4to1_rr

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each input channel and of the output.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  4  bit i high = channel i presents a word.
REQ-005 Port: in_data  input  4*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-006 Port: in_ready  output  4  bit i high = channel i word is accepted this cycle if in_valid[i] is high.
REQ-007 Port: out_valid  output  1  out_data/out_sel hold a word.
REQ-008 Port: out_data  output  WIDTH  merged output word.
REQ-009 Port: out_sel  output  2  source channel index of out_data.
REQ-010 Port: out_ready  input  1  downstream accepts the word when out_valid is high.

Function
REQ-011 The block SHALL merge four valid/ready input streams into one output stream, the inverse of the 1:4 demux; a transfer occurs on any port when valid and ready are both high at a rising clk edge.
REQ-012 Internal state: 2-bit round-robin pointer ptr; output register {out_valid, out_sel, out_data}.
REQ-013 Grant g SHALL be the first i with in_valid[i] high, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); no grant if in_valid = 4'b0000.
REQ-014 Output register SHALL be loadable when out_valid = 0 or out_ready = 1 ("load_en").
REQ-015 in_ready SHALL be one-hot at bit g when a grant exists and load_en = 1, else 4'b0000; at most one bit high per cycle.
REQ-016 On an input transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g+1 mod 4 (3 wraps to 0).
REQ-017 Latency SHALL be one cycle: word accepted at edge k appears on out_data immediately after edge k.
REQ-018 Output transfer with no input transfer on the same edge: out_valid <= 0; out_data, out_sel hold.
REQ-019 Simultaneous output and input transfer on the same edge: register reloads with the new word, out_valid stays 1; full throughput of one word per cycle.
REQ-020 Stall: while out_valid = 1 and out_ready = 0, out_valid, out_data, out_sel SHALL remain stable and in_ready = 4'b0000.
REQ-021 ptr SHALL change only on an input transfer; it SHALL NOT advance while stalled or idle.
REQ-022 A channel dropping in_valid before being granted SHALL lose no accepted data and not alter ptr.
REQ-023 No word SHALL be duplicated or dropped; output order across channels follows grant order.
REQ-024 in_ready SHALL depend combinationally on in_valid, ptr, out_valid, out_ready only (no path from in_data).

Reset
REQ-025 While rst_n = 0 (asserted asynchronously, independent of clk): out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, in_ready = 4'b0000.
REQ-026 Reset mid-operation SHALL discard any held output word; after rst_n rises, the first grant searches from channel 0.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk edge; no transfer occurs on an edge where rst_n is low.

Verification
REQ-028 After reset, in_valid = 4'b0100, in_data ch2 = 8'hA5, out_ready = 1 -> in_ready = 4'b0100; next cycle out_valid = 1, out_data = 8'hA5, out_sel = 2; ptr = 3.
REQ-029 All four channels valid continuously (data 8'h10,8'h21,8'h32,8'h43), out_ready = 1 -> out_sel sequence 0,1,2,3,0,... one word per cycle, out_valid never drops.
REQ-030 ptr = 3, in_valid = 4'b1001 -> channel 3 granted first, then channel 0 (wrap), out_sel 3 then 0.
REQ-031 out_valid = 1 holding 8'h5A, out_ready = 0 for 3 cycles with in_valid = 4'b1111 -> out_data stays 8'h5A, in_ready = 4'b0000, ptr unchanged; out_ready = 1 -> next word loads same edge.
REQ-032 Word held (out_valid = 1), rst_n pulsed low mid-cycle -> out_valid, out_data, out_sel, in_ready drop to 0 immediately without a clk edge; first post-reset grant from channel 0.
REQ-033 in_valid = 4'b0000, out_ready = 1, one word held -> out_valid falls after one edge, out_data holds last value, ptr unchanged.

Source files
------------

// File: rtl/mux_4to1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4to1_rr
//  Description : Four-input valid/ready stream merger with round-robin
//                arbitration and a single registered output stage.
//                Full throughput of one word per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_4to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_valid,
    input  logic [4*WIDTH-1:0]   in_data,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel,
    input  logic                 out_ready
);

    localparam logic [3:0] c_ONE_HOT_BASE = 4'b0001;

    // Round-robin pointer and output register
    logic [1:0]       ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]       out_sel_q,   out_sel_d;

    logic             w_grant_vld;
    logic [1:0]       w_grant_idx;
    logic             w_load_en;
    logic             w_in_xfer;

    // Search ptr, ptr+1, ptr+2, ptr+3; iterating from the farthest offset
    // down lets the nearest requesting channel overwrite the result last.
    always_comb begin : g_arbiter
        logic [1:0] cand;
        w_grant_vld = 1'b0;
        w_grant_idx = ptr_q;
        cand        = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (in_valid[cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    // The output register can take a new word when empty or being drained.
    assign w_load_en = !out_valid_q || out_ready;
    assign w_in_xfer = w_grant_vld && w_load_en;

    // One-hot ready to the granted channel; forced low while in reset so no
    // handshake is ever signalled on an edge that cannot load.
    assign in_ready = (rst_n && w_in_xfer) ? (c_ONE_HOT_BASE << w_grant_idx) : 4'b0000;

    // Next-state: load on input transfer, otherwise empty on output transfer.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (w_in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[w_grant_idx*WIDTH +: WIDTH];
            out_sel_d   = w_grant_idx;
            ptr_d       = w_grant_idx + 2'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
`default_nettype wire
